// File: rtl/bsp_irq_ctrl_pkg.sv
// bsp_irq_ctrl_pkg: shared BSP constants for the interrupt controller.
//   Contents: interrupt source bit mapping, vector ID width, ack timeout,
//             CSR word addresses and the request FSM state type.
package bsp_irq_ctrl_pkg;

    localparam int unsigned BSP_AVMM_NUM_IRQ_USED   = 3;
    localparam int unsigned BSP_NUM_INTERRUPT_LINES = 4;

    // Source bit mapping within irq_in / pending / mask
    localparam int unsigned BSP_DMA0_IRQ_BIT   = 0;
    localparam int unsigned BSP_KERNEL_IRQ_BIT = 1;
    localparam int unsigned BSP_DMA1_IRQ_BIT   = 2;

    localparam int unsigned BSP_IRQ_ID_WIDTH    = $clog2(BSP_NUM_INTERRUPT_LINES);
    localparam int unsigned BSP_IRQ_ACK_TIMEOUT = 1024;

    localparam logic [1:0] IRQ_CSR_STATUS = 2'd0;
    localparam logic [1:0] IRQ_CSR_MASK   = 2'd1;
    localparam logic [1:0] IRQ_CSR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } t_irq_fsm;

endpackage

// File: rtl/bsp_rr_arbiter.sv
// bsp_rr_arbiter: combinational round-robin pick.
//   req_i       : request vector, one bit per source
//   ptr_i       : index with highest priority this round
//   grant_o     : first requesting index at or after ptr_i, wrapping
//   any_grant_o : at least one request present
module bsp_rr_arbiter #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         any_grant_o
);

    logic         hi_found, lo_found;
    logic [W-1:0] hi_idx, lo_idx;

    // hi_* tracks the first request at/after the pointer, lo_* the first
    // overall; lo_* is the wrapped-around winner when nothing is above ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i]) begin
                if (!hi_found && (W'(i) >= ptr_i)) begin
                    hi_found = 1'b1;
                    hi_idx   = W'(i);
                end
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = W'(i);
                end
            end
        end
        any_grant_o = lo_found;
        grant_o     = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/bsp_irq_ctrl.sv
// bsp_irq_ctrl: BSP interrupt controller towards the host channel.
//   clk, reset_n           : clock, asynchronous active-low reset
//   irq_in                 : level interrupt sources (edge-captured)
//   csr_*                  : CSR port (STATUS / MASK / COUNT), 1-cycle read latency
//   irq_req_valid/id/ready : one outstanding request with its vector ID
//   irq_ack_valid/id       : host completion; clears the serviced source
module bsp_irq_ctrl
    import bsp_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ      = BSP_AVMM_NUM_IRQ_USED,
    parameter int unsigned IRQ_ID_WIDTH = BSP_IRQ_ID_WIDTH,
    parameter int unsigned ACK_TIMEOUT  = BSP_IRQ_ACK_TIMEOUT,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IRQ-1:0]      irq_in,
    input  logic [1:0]              csr_address,
    input  logic                    csr_write,
    input  logic                    csr_read,
    input  logic [63:0]             csr_writedata,
    output logic [63:0]             csr_readdata,
    output logic                    csr_readdatavalid,
    output logic                    irq_req_valid,
    output logic [IRQ_ID_WIDTH-1:0] irq_req_id,
    input  logic                    irq_req_ready,
    input  logic                    irq_ack_valid,
    input  logic [IRQ_ID_WIDTH-1:0] irq_ack_id
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);

    t_irq_fsm                state_q, state_d;
    logic [NUM_IRQ-1:0]      irq_d_q, pending_q, pending_d, mask_q, mask_d;
    logic [NUM_IRQ-1:0]      rise, eligible, w1c, ack_clr;
    logic                    tmo_flag_q, tmo_flag_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [IRQ_ID_WIDTH-1:0] ptr_q, ptr_d, cur_id_q, cur_id_d, next_ptr, grant;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [63:0]             rdata_q, rdata_d;
    logic                    rvalid_q;
    logic                    any_grant, ack_hit, tmo_fire;
    logic                    wr_status, wr_mask, wr_count;
    logic                    unused_wdata;

    assign unused_wdata = ^{csr_writedata[63:9], csr_writedata[7:NUM_IRQ]};

    assign rise     = irq_in & ~irq_d_q;
    assign eligible = pending_q & ~mask_q;
    assign next_ptr = (cur_id_q == IRQ_ID_WIDTH'(NUM_IRQ - 1)) ? '0 : cur_id_q + 1'b1;

    assign wr_status = csr_write && (csr_address == IRQ_CSR_STATUS);
    assign wr_mask   = csr_write && (csr_address == IRQ_CSR_MASK);
    assign wr_count  = csr_write && (csr_address == IRQ_CSR_COUNT);

    bsp_rr_arbiter #(
        .N (NUM_IRQ),
        .W (IRQ_ID_WIDTH)
    ) u_arb (
        .req_i       (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .any_grant_o (any_grant)
    );

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        ptr_d     = ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        ack_clr   = '0;
        ack_hit   = 1'b0;
        tmo_fire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_grant) begin
                    cur_id_d = grant;
                    state_d  = REQ;
                end
            end
            // Request is latched: later mask/W1C changes do not withdraw it.
            REQ: begin
                if (irq_req_ready) begin
                    tmo_cnt_d = TMO_W'(ACK_TIMEOUT - 1);
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (irq_ack_valid && (irq_ack_id == cur_id_q)) begin
                    ack_hit = 1'b1;
                    ack_clr = NUM_IRQ'(1) << cur_id_q;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else if (tmo_cnt_q == '0) begin
                    tmo_fire = 1'b1;
                    ptr_d    = next_ptr;
                    state_d  = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge in the same cycle as a clear keeps the source pending.
    always_comb begin
        w1c        = wr_status ? csr_writedata[NUM_IRQ-1:0] : '0;
        pending_d  = (pending_q & ~(w1c | ack_clr)) | rise;
        tmo_flag_d = tmo_fire | (tmo_flag_q & ~(wr_status & csr_writedata[8]));
        mask_d     = wr_mask ? csr_writedata[NUM_IRQ-1:0] : mask_q;
        count_d    = count_q;
        if (wr_count) begin
            count_d = '0;
        end else if (ack_hit && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        unique case (csr_address)
            IRQ_CSR_STATUS: begin
                rdata_d[NUM_IRQ-1:0] = pending_q;
                rdata_d[8]           = tmo_flag_q;
                rdata_d[17:16]       = state_q;
            end
            IRQ_CSR_MASK:  rdata_d[NUM_IRQ-1:0]   = mask_q;
            IRQ_CSR_COUNT: rdata_d[CNT_WIDTH-1:0] = count_q;
            default:       rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            irq_d_q    <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            tmo_flag_q <= 1'b0;
            count_q    <= '0;
            ptr_q      <= '0;
            cur_id_q   <= '0;
            tmo_cnt_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_d_q    <= irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            tmo_flag_q <= tmo_flag_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            cur_id_q   <= cur_id_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rdata_q    <= csr_read ? rdata_d : '0;
            rvalid_q   <= csr_read;
        end
    end

    // Valid decoded from state so an asynchronous reset drops it at once.
    assign irq_req_valid     = (state_q == REQ);
    assign irq_req_id        = cur_id_q;
    assign csr_readdata      = rdata_q;
    assign csr_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_bsp_irq_ctrl.sv
// tb_bsp_irq_ctrl: directed-vector bench for bsp_irq_ctrl (ACK_TIMEOUT=16).
module tb_bsp_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  irq_in;
    logic [1:0]  csr_address;
    logic        csr_write, csr_read;
    logic [63:0] csr_writedata, csr_readdata;
    logic        csr_readdatavalid;
    logic        irq_req_valid, irq_req_ready, irq_ack_valid;
    logic [1:0]  irq_req_id, irq_ack_id;
    logic [63:0] rd;

    int n_checks = 0;
    int n_fail   = 0;

    bsp_irq_ctrl #(
        .NUM_IRQ      (3),
        .IRQ_ID_WIDTH (2),
        .ACK_TIMEOUT  (16),
        .CNT_WIDTH    (32)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .irq_in            (irq_in),
        .csr_address       (csr_address),
        .csr_write         (csr_write),
        .csr_read          (csr_read),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .irq_req_valid     (irq_req_valid),
        .irq_req_id        (irq_req_id),
        .irq_req_ready     (irq_req_ready),
        .irq_ack_valid     (irq_ack_valid),
        .irq_ack_id        (irq_ack_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [2:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [63:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        tick();
        csr_write     = 1'b0;
        csr_writedata = '0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [63:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        tick();
        csr_read    = 1'b0;
        check_eq("rdvalid", 64'(csr_readdatavalid), 64'd1);
        d = csr_readdata;
    endtask

    task automatic wait_req(input string tag);
        int unsigned n = 0;
        while (!irq_req_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(irq_req_valid), 64'd1);
    endtask

    // Needs irq_req_ready=1: accepted on the next edge, then acked.
    task automatic serve(input logic [1:0] exp_id);
        wait_req("serve_valid");
        check_eq("serve_id", 64'(irq_req_id), 64'(exp_id));
        tick();
        irq_ack_valid = 1'b1;
        irq_ack_id    = exp_id;
        tick();
        irq_ack_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; irq_in = '0; csr_address = '0; csr_write = 1'b0;
        csr_read = 1'b0; csr_writedata = '0; irq_req_ready = 1'b1;
        irq_ack_valid = 1'b0; irq_ack_id = '0;
        do_reset();

        // Reset state
        check_eq("rst_valid", 64'(irq_req_valid), 64'd0);
        check_eq("rst_id", 64'(irq_req_id), 64'd0);
        check_eq("rst_rdvalid", 64'(csr_readdatavalid), 64'd0);
        csr_rd(2'd0, rd); check_eq("rst_status", rd, 64'h0);
        csr_rd(2'd1, rd); check_eq("rst_mask", rd, 64'h0);
        csr_rd(2'd2, rd); check_eq("rst_count", rd, 64'h0);
        csr_rd(2'd3, rd); check_eq("rst_addr3", rd, 64'h0);

        // Single source: edge at N, valid at N+2
        irq_in = 3'b010;
        tick();
        irq_in = '0;
        check_eq("lat_n1", 64'(irq_req_valid), 64'd0);
        tick();
        check_eq("lat_n2", {62'd0, irq_req_valid, 1'b0} | 64'(irq_req_id), 64'h3);
        tick();
        check_eq("req_drop", 64'(irq_req_valid), 64'd0);
        irq_ack_valid = 1'b1; irq_ack_id = 2'd2;
        tick();
        irq_ack_valid = 1'b0;
        csr_rd(2'd0, rd); check_eq("bad_ack_status", rd, 64'h2_0002);
        irq_ack_valid = 1'b1; irq_ack_id = 2'd1;
        tick();
        irq_ack_valid = 1'b0;
        csr_rd(2'd0, rd); check_eq("ack_status", rd, 64'h0);
        csr_rd(2'd2, rd); check_eq("ack_count", rd, 64'h1);

        // Round-robin from pointer 0, then wrap
        do_reset();
        pulse(3'b111);
        serve(2'd0); serve(2'd1); serve(2'd2);
        pulse(3'b101);
        serve(2'd0); serve(2'd2);
        csr_rd(2'd2, rd); check_eq("rr_count", rd, 64'h5);
        csr_wr(2'd2, 64'h0);
        csr_rd(2'd2, rd); check_eq("count_clr", rd, 64'h0);

        // Mask
        csr_wr(2'd1, 64'h2);
        pulse(3'b010);
        repeat (4) tick();
        check_eq("mask_noreq", 64'(irq_req_valid), 64'd0);
        csr_rd(2'd0, rd); check_eq("mask_status", rd, 64'h2);
        csr_rd(2'd1, rd); check_eq("mask_rd", rd, 64'h2);
        csr_wr(2'd1, 64'h0);
        serve(2'd1);

        // Backpressure with a mask write mid-stall
        irq_req_ready = 1'b0;
        pulse(3'b001);
        wait_req("bp_valid");
        for (int i = 0; i < 50; i++) begin
            check_eq("bp_hold", {61'd0, irq_req_valid, irq_req_id}, 64'h4);
            if (i == 20) begin
                csr_address = 2'd1; csr_writedata = 64'h1; csr_write = 1'b1;
            end else begin
                csr_write = 1'b0;
            end
            tick();
        end
        csr_write = 1'b0;
        irq_req_ready = 1'b1;
        tick();
        check_eq("bp_accept", 64'(irq_req_valid), 64'd0);
        irq_ack_valid = 1'b1; irq_ack_id = 2'd0;
        tick();
        irq_ack_valid = 1'b0;
        csr_wr(2'd1, 64'h0);

        // Timeout: WAIT_ACK lasts 16 cycles, then re-issue
        pulse(3'b100);
        wait_req("tmo_valid");
        check_eq("tmo_id", 64'(irq_req_id), 64'd2);
        tick();
        repeat (15) tick();
        check_eq("tmo_wait", 64'(irq_req_valid), 64'd0);
        tick();
        check_eq("tmo_idle", 64'(irq_req_valid), 64'd0);
        csr_address = 2'd0; csr_read = 1'b1;
        tick();
        csr_read = 1'b0;
        check_eq("tmo_status", csr_readdata, 64'h104);
        check_eq("tmo_reissue", {61'd0, irq_req_valid, irq_req_id}, 64'h6);
        tick();
        irq_ack_valid = 1'b1; irq_ack_id = 2'd2;
        tick();
        irq_ack_valid = 1'b0;
        csr_wr(2'd0, 64'h100);
        csr_rd(2'd0, rd); check_eq("tmo_w1c", rd, 64'h0);

        // W1C colliding with a new edge; level held high does not re-set
        csr_wr(2'd1, 64'h4);
        pulse(3'b100);
        tick();
        csr_address = 2'd0; csr_writedata = 64'h4; csr_write = 1'b1; irq_in = 3'b100;
        tick();
        csr_write = 1'b0;
        csr_rd(2'd0, rd); check_eq("collide", rd, 64'h4);
        csr_wr(2'd0, 64'h4);
        csr_rd(2'd0, rd); check_eq("level_w1c", rd, 64'h0);
        irq_in = '0;

        // Reset during REQ
        irq_req_ready = 1'b0;
        pulse(3'b010);
        wait_req("rst_req_valid");
        csr_rd(2'd2, rd); check_eq("pre_rst_count", rd, 64'h3);
        check_eq("pre_rst_valid", 64'(irq_req_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_eq("async_drop", 64'(irq_req_valid), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        irq_req_ready = 1'b1;
        tick();
        csr_rd(2'd0, rd); check_eq("post_status", rd, 64'h0);
        csr_rd(2'd1, rd); check_eq("post_mask", rd, 64'h0);
        csr_rd(2'd2, rd); check_eq("post_count", rd, 64'h0);
        check_eq("post_valid", 64'(irq_req_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsp_irq_ctrl.md
Name: bsp_irq_ctrl

Overview:
- Interrupt controller between the BSP interrupt sources (DMA_0, kernel, DMA_1) and the host-channel interrupt request/ack interface.
- Edge-captures each source into a pending register and applies a CSR mask.
- Round-robin arbitrates pending sources and issues one request at a time with its vector ID, then waits for the host ack before clearing that source.

Parameters:
- NUM_IRQ, 3, number of used sources (matches BSP_AVMM_NUM_IRQ_USED). Bit 0 = DMA_0, bit 1 = kernel, bit 2 = DMA_1.
- IRQ_ID_WIDTH, 2, vector ID width (log2 of BSP_NUM_INTERRUPT_LINES = 4).
- ACK_TIMEOUT, 1024, cycles to wait for an ack before abandoning a request; must be ≥ 2.
- CNT_WIDTH, 32, width of the serviced-interrupt counter.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  level interrupt sources, already synchronous to clk.
- csr_address  in  2  word address.
- csr_write  in  1  CSR write strobe.
- csr_read  in  1  CSR read strobe.
- csr_writedata  in  64  CSR write data.
- csr_readdata  out  64  CSR read data.
- csr_readdatavalid  out  1  read data valid.
- irq_req_valid  out  1  interrupt request valid.
- irq_req_id  out  IRQ_ID_WIDTH  vector ID of the request.
- irq_req_ready  in  1  host accepts the request.
- irq_ack_valid  in  1  host completion of a serviced vector.
- irq_ack_id  in  IRQ_ID_WIDTH  vector ID being acked.

Behaviour:
- Reset: all outputs 0; pending 0; mask 0 (all enabled); timeout flag 0; counter 0; RR pointer 0; FSM in IDLE.
- Edge capture:
  - Register irq_in once (irq_d).
  - A rising edge (irq_in & ~irq_d) sets pending[i] on the next cycle.
  - A level held high does not re-set pending after it is cleared.
- Eligible = pending & ~mask.
- FSM IDLE:
  - If any eligible bit is set, the RR winner is the first eligible index at or after the pointer, wrapping.
  - Latch cur_id = winner and assert irq_req_valid the next cycle → REQ.
- FSM REQ:
  - irq_req_valid and irq_req_id are held stable until irq_req_ready. Masking or W1C of the source while in REQ does not withdraw the request.
  - On the ready cycle: deassert valid next cycle, load timeout counter = ACK_TIMEOUT-1, → WAIT_ACK.
- FSM WAIT_ACK:
  - On irq_ack_valid with irq_ack_id == cur_id: clear pending[cur_id], increment counter (saturating at all-ones), pointer = cur_id+1 mod NUM_IRQ, → IDLE.
  - An ack with a mismatched ID is ignored.
  - If the counter reaches 0 with no ack: set sticky timeout flag, leave pending set, pointer = cur_id+1, → IDLE.
- Ack arriving in IDLE or REQ: ignored.
- Simultaneous clear and new edge on the same source in the same cycle (ack clear or W1C): the new edge wins and pending stays 1.
- Minimum latency: edge at cycle N → pending at N+1 → irq_req_valid at N+2.
- One request is outstanding at a time; back-to-back requests need at least one IDLE cycle.
- CSR reads: 1-cycle latency; csr_readdatavalid pulses one cycle after csr_read.
  - Address 0 STATUS: [NUM_IRQ-1:0] pending, bit 8 timeout, [17:16] FSM state. Write-1-to-clear on pending and timeout.
  - Address 1 MASK: RW, [NUM_IRQ-1:0].
  - Address 2 COUNT: RO, counter value; any write clears it.
  - Address 3: reads 0.
- Reset asserted mid-operation: request dropped immediately (asynchronous); all state returns to reset values.

Decomposition:
- dc_bsp_pkg additions:
  - BSP_IRQ_ID_WIDTH.
  - BSP_IRQ_ACK_TIMEOUT.
  - CSR address constants (IRQ_CSR_STATUS/MASK/COUNT).
  - Enum type t_irq_fsm {IDLE, REQ, WAIT_ACK}.
- Existing BSP_*_IRQ_BIT constants are reused for the bit mapping.
- Sub-module bsp_rr_arbiter:
  - Parameter N; inputs req[N] and ptr.
  - Outputs grant index and any_grant.
  - Purely combinational, reusable.

Test Plan:
- Single source: pulse irq_in[1] for 1 cycle at cycle 10, ready tied to 1 → irq_req_valid=1 with id=1 at cycle 12. Ack id=1 at cycle 20 → pending=0, COUNT=1.
- Round-robin: all three edges in the same cycle, immediate ready/ack → request IDs in order 0,1,2. Edge on 0 again → next ID is 0, pointer wrapped.
- Mask: MASK=0b010, edge on 1 → no request, STATUS pending=0b010. Write MASK=0 → request id=1 follows.
- Backpressure: hold irq_req_ready=0 for 50 cycles → valid/id stable throughout. A mask written during the stall does not drop the request.
- Timeout: no ack for ACK_TIMEOUT cycles → STATUS bit 8=1, pending still set, FSM IDLE, request re-issued. W1C 0x100 → bit 8 clears.
- Collision and reset: W1C of bit 2 in the same cycle as a new edge on irq_in[2] → pending[2]=1. Assert reset_n=0 during REQ → irq_req_valid=0 the same cycle and all CSRs read reset values.
